// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit : iterative RV32M multiply/divide (32-cycle shift-add / restoring)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] a_q, a_d;
  logic [31:0] result_q, result_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;

  logic        signed_a, signed_b, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_step, prod_fin;
  logic [31:0] quo_step, rem_step, quo_fin, rem_fin;

  // acc holds the product high half / partial remainder; sh holds the
  // multiplier / dividend being shifted out while result bits shift in.
  always_comb begin
    signed_a  = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    signed_b  = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg     = signed_a & op_a[31];
    b_neg     = signed_b & op_b[31];
    a_mag     = a_neg ? (~op_a + 32'd1) : op_a;
    b_mag     = b_neg ? (~op_b + 32'd1) : op_b;

    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : 33'd0);
    prod_step = {mul_sum, sh_q[31:1]};
    prod_fin  = neg_q ? (~prod_step + 64'd1) : prod_step;

    div_shift = {acc_q, sh_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    rem_step  = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
    quo_step  = {sh_q[30:0], ~div_diff[32]};
    quo_fin   = neg_q ? (~quo_step + 32'd1) : quo_step;
    rem_fin   = neg_rem_q ? (~rem_step + 32'd1) : rem_step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d     = funct3[1:0];
          acc_d     = 32'd0;
          sh_d      = a_mag;
          opnd_d    = b_mag;
          a_d       = op_a;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = funct3[2] & (op_b == 32'd0);
          ovf_d     = funct3[2] & ~funct3[0] & (op_a == 32'h8000_0000) &
                      (op_b == 32'hFFFF_FFFF);
          cnt_d     = 5'd0;
          state_d   = funct3[2] ? DIV : MUL;
        end
      end
      MUL: begin
        acc_d = prod_step[63:32];
        sh_d  = prod_step[31:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = DONE;
          result_d = (sel_q == 2'b00) ? prod_fin[31:0] : prod_fin[63:32];
        end
      end
      DIV: begin
        if (dz_q) begin
          state_d  = DONE;
          result_d = sel_q[1] ? a_q : 32'hFFFF_FFFF;
        end else if (ovf_q) begin
          state_d  = DONE;
          result_d = sel_q[1] ? 32'd0 : 32'h8000_0000;
        end else begin
          acc_d = rem_step;
          sh_d  = quo_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = DONE;
            result_d = sel_q[1] ? rem_fin : quo_fin;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      sel_q     <= 2'd0;
      acc_q     <= 32'd0;
      sh_q      <= 32'd0;
      opnd_q    <= 32'd0;
      a_q       <= 32'd0;
      result_q  <= 32'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      result_q  <= result_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy   = (state_q == MUL) || (state_q == DIV);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit : vector table + scoreboard bench for mul_div_unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] exp;
    int          k;
    int          lat;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  localparam int NVEC = 22;
  vec_t tbl[NVEC];

  mul_div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard consumer: every done pulse must match the oldest issued op.
  always @(negedge clk) begin
    sb_t e;
    if (!rst && done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done with result=%h, required no done", result);
      end else begin
        e = sb_q.pop_front();
        if (result !== e.exp) begin
          errors++;
          $display("FAIL result: got %h, required %h", result, e.exp);
        end
        checks++;
        if (cyc - e.k != e.lat) begin
          errors++;
          $display("FAIL done_latency: got %0d edges, required %0d", cyc - e.k, e.lat);
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int p1, input int p2);
    int nb;
    bit got;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    sb_q.push_back('{exp, cyc + 1, lat});
    @(negedge clk);
    start = 1'b0;
    nb    = 0;
    got   = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      op_a   = $urandom;
      op_b   = $urandom;
      funct3 = 3'($urandom);
      start  = (i == p1 - 1) || (i == p2 - 1);
      if (busy) nb++;
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: got no done in 40 cycles, required done", name);
      sb_q.delete();
    end
    checks++;
    if (nb != lat) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, required %0d", name, nb, lat);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL %s after_done: got busy=%b done=%b result=%h, required 0 0 %h",
               name, busy, done, result, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32};
    tbl[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32};
    tbl[2]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32};
    tbl[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32};
    tbl[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32};
    tbl[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        32};
    tbl[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         32};
    tbl[8]  = '{3'b101, 32'd1234,      32'd0,         32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1};
    tbl[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    tbl[12] = '{3'b000, 32'd0,         32'd12345,     32'd0,         32};
    tbl[13] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32};
    tbl[14] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
    tbl[15] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32};
    tbl[16] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32};
    tbl[17] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         32};
    tbl[18] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32};
    tbl[19] = '{3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 32};
    tbl[20] = '{3'b100, 32'h8000_0000, 32'd1,         32'h8000_0000, 32};
    tbl[21] = '{3'b100, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1};

    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'd0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h, required 0 0 0",
               busy, done, result);
    end
    rst = 1'b0;

    for (int v = 0; v < NVEC; v++)
      run_op($sformatf("vec%0d", v), tbl[v].f, tbl[v].a, tbl[v].b, tbl[v].exp,
             tbl[v].lat, -1, -1);

    // Extra start pulses mid-operation, at the last iteration and in DONE.
    run_op("divu_pulses", 3'b101, 32'd1000, 32'd10, 32'd100, 32, 5, 32);
    run_op("divu_done_start", 3'b101, 32'd50, 32'd7, 32'd7, 32, -1, 33);

    // Abort a multiply with reset part-way through.
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd3;
    op_b   = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b done=%b result=%h, required 0 0 0",
               busy, done, result);
    end
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_dominates: got busy=%b done=%b, required 0 0", busy, done);
      end
    end
    rst   = 1'b0;
    start = 1'b0;

    run_op("divu_after_reset", 3'b101, 32'd9, 32'd3, 32'd3, 32, -1, -1);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
